// File: rtl/core_regfile_pkg.sv
// Shared widths, types and small helpers for the integer register file.
package core_regfile_pkg;

   localparam int XLEN = 64;
   localparam int IDXW = 5;
   localparam int NREG = 2 ** IDXW;

   typedef logic [XLEN-1:0] xlen_t;
   typedef logic [IDXW-1:0] ridx_t;

   // True when an enabled index matches a target index (bypass, clear and set hits).
   function automatic logic idxHit(input logic en, input ridx_t a, input ridx_t b);
      return en && (a == b);
   endfunction

endpackage

// File: rtl/core_regfile_if.sv
// Bundle between the ID/WB stages and the register file.
// The master side is the pipeline; the slave side is the register file.
interface core_regfile_if;
   import core_regfile_pkg::*;

   logic  wb_we;
   ridx_t wb_idx;
   xlen_t wb_data;
   ridx_t rs1_idx;
   ridx_t rs2_idx;
   logic  rs1_used;
   logic  rs2_used;
   xlen_t rs1_data;
   xlen_t rs2_data;
   logic  sb_set;
   ridx_t sb_idx;
   logic  flush;
   logic  stall_o;

   modport master (
      output wb_we, wb_idx, wb_data,
      output rs1_idx, rs2_idx, rs1_used, rs2_used,
      output sb_set, sb_idx, flush,
      input  rs1_data, rs2_data, stall_o
   );

   modport slave (
      input  wb_we, wb_idx, wb_data,
      input  rs1_idx, rs2_idx, rs1_used, rs2_used,
      input  sb_set, sb_idx, flush,
      output rs1_data, rs2_data, stall_o
   );

endinterface

// File: rtl/core_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register marking a result still in flight,
// plus the operand hazard (stall) evaluation for the two ID read ports.
module core_rf_scoreboard
   import core_regfile_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  wb_we_i,
   input  ridx_t wb_idx_i,
   input  logic  sb_set_i,
   input  ridx_t sb_idx_i,
   input  logic  flush_i,
   input  ridx_t rs1_idx_i,
   input  ridx_t rs2_idx_i,
   input  logic  rs1_used_i,
   input  logic  rs2_used_i,
   output logic  stall_o
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic            rs1Busy;
   logic            rs2Busy;

   // Next pending vector: flush clears everything except a same-cycle issue,
   // a new issue beats a same-cycle write-back because its producer is younger,
   // and x0 can never be pending.
   always_comb begin
      pending_d = pending_q;
      for (int i = 1; i < NREG; i++) begin
         if (flush_i) begin
            pending_d[i] = idxHit(sb_set_i, sb_idx_i, ridx_t'(i));
         end else if (idxHit(sb_set_i, sb_idx_i, ridx_t'(i))) begin
            pending_d[i] = 1'b1;
         end else if (idxHit(wb_we_i, wb_idx_i, ridx_t'(i))) begin
            pending_d[i] = 1'b0;
         end
      end
      pending_d[0] = 1'b0;
   end

   // Pending register; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // An operand is busy while pending, unless its write-back lands this cycle
   // (the bypass forwards it), and only stalls when the instruction reads it.
   always_comb begin
      rs1Busy = pending_q[rs1_idx_i] && !idxHit(wb_we_i, wb_idx_i, rs1_idx_i);
      rs2Busy = pending_q[rs2_idx_i] && !idxHit(wb_we_i, wb_idx_i, rs2_idx_i);
      stall_o = (rs1_used_i && rs1Busy) || (rs2_used_i && rs2Busy);
   end

endmodule

// File: rtl/core_regfile.sv
// RV64 integer register file: 32 x XLEN storage with x0 hardwired to zero,
// two combinational read ports with write-back bypass, and a pending-write scoreboard.
module core_regfile
   import core_regfile_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   core_regfile_if.slave rf
);

   xlen_t regs_q [NREG];

   // Storage array; writes aimed at x0 are dropped so entry 0 stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (rf.wb_we && (rf.wb_idx != '0)) begin
         regs_q[rf.wb_idx] <= rf.wb_data;
      end
   end

   // Read port 1: zero for x0, same-cycle write-back data if it hits, else the array.
   always_comb begin
      rf.rs1_data = '0;
      if (rf.rs1_idx != '0) begin
         if (idxHit(rf.wb_we, rf.wb_idx, rf.rs1_idx)) begin
            rf.rs1_data = rf.wb_data;
         end else begin
            rf.rs1_data = regs_q[rf.rs1_idx];
         end
      end
   end

   // Read port 2: same selection as port 1, fully independent.
   always_comb begin
      rf.rs2_data = '0;
      if (rf.rs2_idx != '0) begin
         if (idxHit(rf.wb_we, rf.wb_idx, rf.rs2_idx)) begin
            rf.rs2_data = rf.wb_data;
         end else begin
            rf.rs2_data = regs_q[rf.rs2_idx];
         end
      end
   end

   core_rf_scoreboard uScoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_we_i    (rf.wb_we),
      .wb_idx_i   (rf.wb_idx),
      .sb_set_i   (rf.sb_set),
      .sb_idx_i   (rf.sb_idx),
      .flush_i    (rf.flush),
      .rs1_idx_i  (rf.rs1_idx),
      .rs2_idx_i  (rf.rs2_idx),
      .rs1_used_i (rf.rs1_used),
      .rs2_used_i (rf.rs2_used),
      .stall_o    (rf.stall_o)
   );

endmodule

// File: tb/tb_core_regfile.sv
// Self-checking bench for core_regfile: directed cases followed by random traffic,
// compared against an architectural model (plain register array + pending flags).
module tb_core_regfile;
   import core_regfile_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   core_regfile_if rfIf ();

   core_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rfIf)
   );

   // Free-running core clock, 10 ns period.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] modelRegs [32];
   bit          modelPend [32];

   // Compare one observed value with the expected one and report any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void clearModel();
      for (int i = 0; i < 32; i++) begin
         modelRegs[i] = '0;
         modelPend[i] = 1'b0;
      end
   endfunction

   // Architectural read: x0 is zero, a write-back in the same cycle is visible, else stored value.
   function automatic logic [63:0] modelRead(input int idx);
      if (idx == 0) return '0;
      if (rfIf.wb_we && (int'(rfIf.wb_idx) == idx)) return rfIf.wb_data;
      return modelRegs[idx];
   endfunction

   function automatic bit modelBusy(input int idx);
      return modelPend[idx] && !(rfIf.wb_we && (int'(rfIf.wb_idx) == idx));
   endfunction

   function automatic bit modelStall();
      return (rfIf.rs1_used && modelBusy(int'(rfIf.rs1_idx))) ||
             (rfIf.rs2_used && modelBusy(int'(rfIf.rs2_idx)));
   endfunction

   // Drive one cycle of inputs after the falling edge and check the combinational outputs.
   task automatic applyStimulus(input bit we, input int widx, input logic [63:0] wdata,
                                input int r1, input int r2, input bit u1, input bit u2,
                                input bit set, input int sidx, input bit fl);
      @(negedge clk);
      rfIf.wb_we    = we;
      rfIf.wb_idx   = IDXW'(widx);
      rfIf.wb_data  = wdata;
      rfIf.rs1_idx  = IDXW'(r1);
      rfIf.rs2_idx  = IDXW'(r2);
      rfIf.rs1_used = u1;
      rfIf.rs2_used = u2;
      rfIf.sb_set   = set;
      rfIf.sb_idx   = IDXW'(sidx);
      rfIf.flush    = fl;
      #1;
      checkOutput("rs1_data", rfIf.rs1_data, modelRead(r1));
      checkOutput("rs2_data", rfIf.rs2_data, modelRead(r2));
      checkOutput("stall", 64'(rfIf.stall_o), 64'(modelStall()));
   endtask

   // Advance through the rising edge and apply the architectural update to the model.
   task automatic stepClock();
      int w;
      int s;
      @(posedge clk);
      if (rst_n) begin
         w = int'(rfIf.wb_idx);
         s = int'(rfIf.sb_idx);
         if (rfIf.wb_we && w != 0) modelRegs[w] = rfIf.wb_data;
         for (int i = 1; i < 32; i++) begin
            if (rfIf.flush) modelPend[i] = rfIf.sb_set && (s == i);
            else if (rfIf.sb_set && s == i) modelPend[i] = 1'b1;
            else if (rfIf.wb_we && w == i) modelPend[i] = 1'b0;
         end
      end
   endtask

   task automatic idleInputs();
      rfIf.wb_we    = 1'b0;
      rfIf.wb_idx   = '0;
      rfIf.wb_data  = '0;
      rfIf.rs1_idx  = '0;
      rfIf.rs2_idx  = '0;
      rfIf.rs1_used = 1'b0;
      rfIf.rs2_used = 1'b0;
      rfIf.sb_set   = 1'b0;
      rfIf.sb_idx   = '0;
      rfIf.flush    = 1'b0;
   endtask

   // Assert reset mid-cycle, confirm outputs clear before any edge, sweep every index, release.
   task automatic resetPulse();
      #2;
      rst_n = 1'b0;
      idleInputs();
      rfIf.rs1_idx  = 5'd5;
      rfIf.rs2_idx  = 5'd7;
      rfIf.rs1_used = 1'b1;
      rfIf.rs2_used = 1'b1;
      #1;
      clearModel();
      checkOutput("async rst rs1", rfIf.rs1_data, 64'h0);
      checkOutput("async rst rs2", rfIf.rs2_data, 64'h0);
      checkOutput("async rst stall", 64'(rfIf.stall_o), 64'h0);
      for (int i = 0; i < 32; i++) begin
         rfIf.rs1_idx = IDXW'(i);
         rfIf.rs2_idx = IDXW'(31 - i);
         #1;
         checkOutput("rst rs1 sweep", rfIf.rs1_data, 64'h0);
         checkOutput("rst rs2 sweep", rfIf.rs2_data, 64'h0);
         checkOutput("rst stall sweep", 64'(rfIf.stall_o), 64'h0);
      end
      idleInputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int randIdx();
      if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
      return int'($urandom_range(0, 31));
   endfunction

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed cases, then random traffic, then the summary.
   initial begin
      rst_n = 1'b0;
      idleInputs();
      clearModel();
      #12;
      for (int i = 0; i < 32; i++) begin
         rfIf.rs1_idx = IDXW'(i);
         rfIf.rs2_idx = IDXW'(31 - i);
         rfIf.rs1_used = 1'b1;
         rfIf.rs2_used = 1'b1;
         #1;
         checkOutput("reset rs1", rfIf.rs1_data, 64'h0);
         checkOutput("reset rs2", rfIf.rs2_data, 64'h0);
         checkOutput("reset stall", 64'(rfIf.stall_o), 64'h0);
      end
      idleInputs();
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 5, 0, 0, 0, 0, 0, 0);
      checkOutput("x5 readback", rfIf.rs1_data, 64'hDEAD_BEEF_0000_0001);
      stepClock();

      applyStimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0 no bypass", rfIf.rs1_data, 64'h0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0 stays zero", rfIf.rs1_data, 64'h0);
      stepClock();

      applyStimulus(1, 7, 64'h1234, 7, 7, 0, 0, 0, 0, 0);
      checkOutput("bypass rs1", rfIf.rs1_data, 64'h1234);
      checkOutput("bypass rs2", rfIf.rs2_data, 64'h1234);
      stepClock();
      applyStimulus(0, 0, 64'h0, 7, 7, 0, 0, 0, 0, 0);
      checkOutput("x7 array rs1", rfIf.rs1_data, 64'h1234);
      checkOutput("x7 array rs2", rfIf.rs2_data, 64'h1234);
      stepClock();

      applyStimulus(0, 0, 64'h0, 0, 0, 0, 0, 1, 10, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 10, 0, 1, 0, 0, 0, 0);
      checkOutput("x10 pending stall", 64'(rfIf.stall_o), 64'h1);
      stepClock();
      applyStimulus(0, 0, 64'h0, 10, 0, 0, 0, 0, 0, 0);
      checkOutput("x10 unused no stall", 64'(rfIf.stall_o), 64'h0);
      stepClock();
      applyStimulus(1, 10, 64'h55, 10, 0, 1, 0, 0, 0, 0);
      checkOutput("x10 wb forward stall", 64'(rfIf.stall_o), 64'h0);
      checkOutput("x10 wb forward data", rfIf.rs1_data, 64'h55);
      stepClock();

      applyStimulus(1, 3, 64'hAAAA_0000_BBBB_3333, 0, 0, 0, 0, 1, 3, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 0, 3, 0, 1, 0, 0, 0);
      checkOutput("set beats clear", 64'(rfIf.stall_o), 64'h1);
      stepClock();
      applyStimulus(1, 3, 64'h3, 0, 3, 0, 1, 0, 0, 0);
      stepClock();

      applyStimulus(0, 0, 64'h0, 0, 0, 0, 0, 1, 4, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 0, 0, 0, 0, 1, 9, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 4, 9, 1, 1, 0, 0, 1);
      checkOutput("pre-flush stall", 64'(rfIf.stall_o), 64'h1);
      stepClock();
      applyStimulus(0, 0, 64'h0, 4, 9, 1, 1, 0, 0, 0);
      checkOutput("post-flush stall", 64'(rfIf.stall_o), 64'h0);
      stepClock();

      applyStimulus(0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0);
      stepClock();
      applyStimulus(0, 0, 64'h0, 0, 0, 1, 1, 0, 0, 0);
      checkOutput("x0 never pending", 64'(rfIf.stall_o), 64'h0);
      stepClock();

      applyStimulus(1, 12, 64'hCAFE_F00D_1234_5678, 0, 0, 0, 0, 1, 12, 0);
      resetPulse();
      applyStimulus(0, 0, 64'h0, 12, 5, 1, 1, 0, 0, 0);
      checkOutput("discarded write", rfIf.rs1_data, 64'h0);
      checkOutput("discarded set", 64'(rfIf.stall_o), 64'h0);
      stepClock();

      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 1) == 1, randIdx(), {$urandom(), $urandom()},
                       randIdx(), randIdx(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, randIdx(), $urandom_range(0, 15) == 0);
         stepClock();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
